// File: rtl/renode_apb3_pkg.sv
// Shared definitions for the APB3 requester arbiter.
//   state_t    : APB3 phase sequencer states (IDLE, SETUP, ACCESS)
//   req_idx_t  : requester index wide enough for the largest supported count (16)
//   next_idx   : round-robin successor of an index for a given requester count
package renode_apb3_pkg;

    localparam int MaxRequesters = 16;
    localparam int IdxWidth      = $clog2(MaxRequesters);

    typedef logic [IdxWidth-1:0] req_idx_t;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_SETUP,
        STATE_ACCESS
    } state_t;

    function automatic req_idx_t next_idx(input req_idx_t idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// Combinational round-robin pick.
//   req   in  N     request vector
//   ptr   in  idx   index that has highest priority this cycle
//   grant out N     one-hot winner (0 when nothing requested)
//   idx   out idx   index of the winner
//   any   out 1     at least one request present
// The pointer register is owned by the parent.
module renode_rr_arbiter
    import renode_apb3_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  req_idx_t     ptr,
    output logic [N-1:0] grant,
    output req_idx_t     idx,
    output logic         any
);

    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk N positions starting at ptr, wrapping; first set bit wins.
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = req_idx_t'(c);
            end
        end
    end

endmodule

// File: rtl/renode_apb3_requester_arbiter.sv
// Shares one APB3 requester port among NumRequesters initiators, round-robin.
// Optional feature macro: APB3_ARB_TIMEOUT_EN (ACCESS-phase timeout abort).
//   clk, rst_n            clock, asynchronous active-low reset
//   req/req_write         per-initiator request level and direction
//   req_addr/req_wdata    flattened per-initiator payload (slice i = initiator i)
//   gnt                   one-hot pulse; payload is captured in this cycle
//   rsp_valid             one-hot completion pulse, with rsp_rdata/rsp_err
//   timeout               abort pulse (constant 0 without the macro)
//   paddr/pwrite/pwdata/psel/penable   APB3 request side
//   pready/pslverr/prdata              APB3 completer response
// Handshake: an initiator holds req until it sees gnt; gnt is combinational
// (IDLE, or the pready cycle of ACCESS) so the transfer is captured on the
// very edge that ends the gnt cycle. Every other output is registered.
module renode_apb3_requester_arbiter
    import renode_apb3_pkg::*;
#(
    parameter int NumRequesters = 4,
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NumRequesters-1:0]               req,
    input  logic [NumRequesters-1:0]               req_write,
    input  logic [NumRequesters*AddressWidth-1:0]  req_addr,
    input  logic [NumRequesters*DataWidth-1:0]     req_wdata,
    output logic [NumRequesters-1:0]               gnt,
    output logic [NumRequesters-1:0]               rsp_valid,
    output logic [DataWidth-1:0]                   rsp_rdata,
    output logic                                   rsp_err,
    output logic                                   timeout,
    output logic [AddressWidth-1:0]                paddr,
    output logic                                   pwrite,
    output logic [DataWidth-1:0]                   pwdata,
    output logic                                   psel,
    output logic                                   penable,
    input  logic                                   pready,
    input  logic                                   pslverr,
    input  logic [DataWidth-1:0]                   prdata
);

    localparam int N  = NumRequesters;
    localparam int AW = AddressWidth;
    localparam int DW = DataWidth;
    localparam logic [N-1:0] One = N'(1);

    state_t   state;
    req_idx_t ptr;
    req_idx_t cur;
    logic     cur_write;

    logic [N-1:0] win;
    req_idx_t     win_idx;
    logic         win_any;

    renode_rr_arbiter #(.N(N)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (win),
        .idx   (win_idx),
        .any   (win_any)
    );

    logic          grant_window;
    logic          take;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_write;
    logic          expire;

    // Grants happen in IDLE or in the completing ACCESS cycle (back-to-back).
    // Gated by rst_n so every output is 0 while reset is held.
    assign grant_window = (state == STATE_IDLE) || ((state == STATE_ACCESS) && pready);
    assign take         = rst_n && grant_window && win_any;
    assign gnt          = take ? win : '0;

    always_comb begin
        sel_addr  = req_addr[int'(win_idx)*AW +: AW];
        sel_wdata = req_wdata[int'(win_idx)*DW +: DW];
        sel_write = req_write[win_idx];
    end

`ifdef APB3_ARB_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] wait_cnt;

    // wait_cnt counts completed ACCESS cycles without pready; expire marks
    // the last allowed one.
    assign expire = (wait_cnt == CntWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == STATE_ACCESS) && !pready && expire;
            if (state == STATE_SETUP)
                wait_cnt <= '0;
            else if ((state == STATE_ACCESS) && !pready)
                wait_cnt <= wait_cnt + CntWidth'(1);
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STATE_IDLE;
            ptr       <= '0;
            cur       <= '0;
            cur_write <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (win_any) begin
                        state   <= STATE_SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                    end
                end
                STATE_SETUP: begin
                    state   <= STATE_ACCESS;
                    penable <= 1'b1;
                end
                STATE_ACCESS: begin
                    if (pready) begin
                        rsp_valid <= One << cur;
                        rsp_rdata <= cur_write ? '0 : prdata;
                        rsp_err   <= pslverr;
                        penable   <= 1'b0;
                        if (win_any) begin
                            state <= STATE_SETUP;
                        end else begin
                            state <= STATE_IDLE;
                            psel  <= 1'b0;
                        end
                    end else if (expire) begin
                        rsp_valid <= One << cur;
                        rsp_err   <= 1'b1;
                        state     <= STATE_IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                    end
                end
                default: begin
                    state   <= STATE_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
            // Payload capture on every grant; paddr/pwdata otherwise hold.
            if (take) begin
                cur       <= win_idx;
                cur_write <= sel_write;
                ptr       <= next_idx(win_idx, N);
                paddr     <= sel_addr;
                pwrite    <= sel_write;
                pwdata    <= sel_write ? sel_wdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_renode_apb3_requester_arbiter.sv
module tb_renode_apb3_requester_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef APB3_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            timeout;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic            psel;
    logic            penable;
    logic            pready;
    logic            pslverr;
    logic [DW-1:0]   prdata;

    int errors = 0;
    int checks = 0;

    renode_apb3_requester_arbiter #(
        .NumRequesters (N),
        .AddressWidth  (AW),
        .DataWidth     (DW),
        .TimeoutCycles (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .timeout   (timeout),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    // Clock and a global watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Inputs change 2 time units after the rising edge; outputs are checked
    // 1 unit later, well away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; pready = 1'b0; pslverr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One transfer from IDLE with inline checks of grant, SETUP, every ACCESS
    // cycle (payload stability) and the response.
    task automatic run_xfer(input int idx, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int waits,
                            input logic [DW-1:0] rd, input logic err);
        logic [N-1:0]  exp_oh;
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rd;
        exp_oh = N'(1) << idx;
        exp_wd = wr ? wdata : '0;
        exp_rd = wr ? '0 : rd;
        req[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = wdata;
        #1;
        checks++;
        if (gnt !== exp_oh || psel !== 1'b0) begin
            errors++;
            $display("FAIL xfer_gnt: gnt=%b psel=%b, required gnt=%b psel=0", gnt, psel, exp_oh);
        end
        step();
        req[idx] = 1'b0;
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== addr || pwrite !== wr || pwdata !== exp_wd) begin
            errors++;
            $display("FAIL xfer_setup: psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h, required 1 0 %h %b %h",
                     psel, penable, paddr, pwrite, pwdata, addr, wr, exp_wd);
        end
        for (int c = 0; c <= waits; c++) begin
            step();
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== addr || pwrite !== wr ||
                pwdata !== exp_wd || rsp_valid !== '0) begin
                errors++;
                $display("FAIL xfer_access%0d: psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h rsp_valid=%b, required 1 1 %h %b %h 0",
                         c, psel, penable, paddr, pwrite, pwdata, rsp_valid, addr, wr, exp_wd);
            end
            if (c == waits) begin
                pready = 1'b1; pslverr = err; prdata = rd;
            end
        end
        step();
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        checks++;
        if (rsp_valid !== exp_oh || rsp_rdata !== exp_rd || rsp_err !== err || psel !== 1'b0 || penable !== 1'b0) begin
            errors++;
            $display("FAIL xfer_rsp: rsp_valid=%b rdata=%h err=%b psel=%b penable=%b, required %b %h %b 0 0",
                     rsp_valid, rsp_rdata, rsp_err, psel, penable, exp_oh, exp_rd, err);
        end
        step();
        checks++;
        if (rsp_valid !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL xfer_rsp_pulse: rsp_valid=%b rdata=%h err=%b, required all 0", rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '1; req_write = '1; req_addr = '1; req_wdata = '1;
        pready = 1'b1; pslverr = 1'b1; prdata = '1;
        step();
        step();
        #1;
        checks++;
        if (gnt !== '0 || rsp_valid !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: gnt=%b rsp_valid=%b rdata=%h err=%b timeout=%b, required all 0",
                     gnt, rsp_valid, rsp_rdata, rsp_err, timeout);
        end
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || paddr !== '0 || pwrite !== 1'b0 || pwdata !== '0) begin
            errors++;
            $display("FAIL reset_apb: psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h, required all 0",
                     psel, penable, paddr, pwrite, pwdata);
        end
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        run_xfer(0, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_write[i] = 1'b0;
            req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 4);
        end
        req = '1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_first_gnt: gnt=%b, required 0001", gnt);
        end
        for (int k = 0; k < N; k++) begin
            step();
            req[k] = 1'b0;
            pready = 1'b0;
            checks++;
            if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h1000 + 32'(k * 4)) begin
                errors++;
                $display("FAIL b2b_setup%0d: psel=%b penable=%b paddr=%h, required 1 0 %h",
                         k, psel, penable, paddr, 32'h1000 + 32'(k * 4));
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== 4'(1 << (k - 1)) || rsp_rdata !== 32'hA0 + 32'(k - 1)) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: rsp_valid=%b rdata=%h, required %b %h",
                             k - 1, rsp_valid, rsp_rdata, 4'(1 << (k - 1)), 32'hA0 + 32'(k - 1));
                end
            end
            step();
            pready = 1'b1;
            prdata = 32'hA0 + 32'(k);
            #1;
            checks++;
            if (penable !== 1'b1 || gnt !== ((k < N - 1) ? 4'(1 << (k + 1)) : 4'b0000)) begin
                errors++;
                $display("FAIL b2b_gnt%0d: penable=%b gnt=%b, required 1 %b",
                         k, penable, gnt, (k < N - 1) ? 4'(1 << (k + 1)) : 4'b0000);
            end
        end
        step();
        pready = 1'b0; prdata = '0;
        checks++;
        if (psel !== 1'b0 || rsp_valid !== 4'b1000 || rsp_rdata !== 32'hA3) begin
            errors++;
            $display("FAIL b2b_last: psel=%b rsp_valid=%b rdata=%h, required 0 1000 000000a3",
                     psel, rsp_valid, rsp_rdata);
        end
        step();
    endtask

    task automatic test_wait_states();
        run_xfer(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 5, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_pslverr();
        run_xfer(2, 1'b0, 32'h0000_0300, 32'h0, 1, 32'hBAD0_0001, 1'b1);
        run_xfer(3, 1'b1, 32'h0000_0304, 32'hCAFE_0003, 0, 32'h0, 1'b0);
    endtask

    task automatic test_async_reset();
        req_write[1] = 1'b0;
        req_addr[1*AW +: AW] = 32'h80;
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        step();
        #1;
        checks++;
        if (penable !== 1'b1) begin
            errors++;
            $display("FAIL arst_in_access: penable=%b, required 1", penable);
        end
        rst_n = 1'b0;
        req[2] = 1'b1;
        req_write[2] = 1'b0;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || gnt !== '0 || rsp_valid !== '0 || paddr !== '0) begin
            errors++;
            $display("FAIL arst_drop: psel=%b penable=%b gnt=%b rsp_valid=%b paddr=%h, required all 0",
                     psel, penable, gnt, rsp_valid, paddr);
        end
        pready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== '0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL arst_no_rsp: rsp_valid=%b psel=%b, required 0 0", rsp_valid, psel);
        end
        pready = 1'b0;
        step();
        rst_n = 1'b1;
        run_xfer(2, 1'b0, 32'h0000_0500, 32'h0, 0, 32'h5555_AAAA, 1'b0);
        // ptr is now 3: with 0 and 3 requesting, 3 must win.
        req_addr[0*AW +: AW] = 32'h600;
        req_write[0] = 1'b0;
        req[0] = 1'b1;
        req[3] = 1'b1;
        req_write[3] = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL rr_wrap: gnt=%b, required 1000", gnt);
        end
        req[3] = 1'b0;
        do_reset();
    endtask

`ifdef APB3_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_write[0] = 1'b0;
        req_addr[0*AW +: AW] = 32'h200;
        req[0] = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL to_gnt: gnt=%b, required 0001", gnt);
        end
        step();
        req[0] = 1'b0;
        for (int c = 0; c < TO; c++) begin
            step();
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_access%0d: psel=%b penable=%b timeout=%b, required 1 1 0", c, psel, penable, timeout);
            end
        end
        step();
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || timeout !== 1'b1 || rsp_valid !== 4'b0001 ||
            rsp_err !== 1'b1 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL to_abort: psel=%b penable=%b timeout=%b rsp_valid=%b err=%b rdata=%h, required 0 0 1 0001 1 0",
                     psel, penable, timeout, rsp_valid, rsp_err, rsp_rdata);
        end
        step();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: timeout=%b, required 0", timeout);
        end
        run_xfer(1, 1'b0, 32'h0000_0210, 32'h0, 0, 32'h0BAD_F00D, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_pslverr();
        test_async_reset();
`ifdef APB3_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
